// File: rtl/cordic_sweep_ctrl.sv
// cordic_sweep_ctrl: steps the CORDIC core's angle code through a programmed
// range. Each (angle, cos, sin) result is captured on the core's done pulse,
// queued in a small FIFO, and presented downstream with a valid/ready handshake.
//
// Ports:
//   CLK, reset             clock (rising edge), synchronous active-high reset
//   start                  one-cycle sweep request (ignored while busy)
//   busy                   sweep in progress
//   z0_out                 angle code driven to the core's z0 input
//   cordic_done            core result-ready pulse
//   cordic_cos/cordic_sin  core results, signed Q8
//   out_valid/out_ready    downstream handshake for the FIFO head
//   out_angle/out_cos/out_sin  FIFO head payload
//   sweep_done             one-cycle pulse when a sweep completes
//
// Optional macro CORDIC_SWEEP_CONTINUOUS_EN: when the angle passes ANGLE_STOP,
// the sweep restarts from ANGLE_START instead of flushing and returning to idle.
// sweep_done pulses on each wrap, and busy stays high until reset.
//
// FIFO_DEPTH must be a power of two, 2 or greater.

module cordic_sweep_ctrl #(
  parameter int unsigned ANGLE_START = 0,
  parameter int unsigned ANGLE_STOP  = 18,
  parameter int unsigned ANGLE_STEP  = 1,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic [6:0]         z0_out,
  input  logic               cordic_done,
  input  logic signed [15:0] cordic_cos,
  input  logic signed [15:0] cordic_sin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [6:0]         out_angle,
  output logic signed [15:0] out_cos,
  output logic signed [15:0] out_sin,
  output logic               sweep_done
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, PRIME, RUN, FLUSH} state_t;

  typedef struct packed {
    logic [6:0]         angle;
    logic signed [15:0] cos_v;
    logic signed [15:0] sin_v;
  } entry_t;

  state_t           state;
  entry_t           mem [FIFO_DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic [7:0]       next_angle;
  logic             full;
  logic             push;
  logic             pop;
  logic             past_stop;

  // Full/empty come from the registered count, so a pop in the same cycle
  // cannot make room for a push.
  assign full       = (count == CNT_W'(FIFO_DEPTH));
  assign push       = (state == RUN) && cordic_done && !full;
  assign pop        = out_valid && out_ready;
  assign next_angle = {1'b0, z0_out} + 8'(ANGLE_STEP);
  assign past_stop  = (next_angle > 8'(ANGLE_STOP));

  // Present the FIFO head.
  assign head      = mem[rd_ptr];
  assign out_angle = head.angle;
  assign out_cos   = head.cos_v;
  assign out_sin   = head.sin_v;

  // Occupancy after this cycle's push and pop.
  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + CNT_W'(1);
    else if (!push && pop)
      count_next = count - CNT_W'(1);
  end

  // FIFO storage and sweep sequencer.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      z0_out     <= 7'(ANGLE_START);
      sweep_done <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      out_valid  <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++)
        mem[i] <= '0;
    end else begin
      sweep_done <= 1'b0;

      if (push) begin
        mem[wr_ptr] <= '{angle: z0_out, cos_v: cordic_cos, sin_v: cordic_sin};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      count     <= count_next;
      out_valid <= (count_next != '0);

      case (state)
        IDLE: begin
          if (start) begin
            z0_out <= 7'(ANGLE_START);
            busy   <= 1'b1;
            state  <= PRIME;
          end
        end
        // The first pass after start may have loaded a stale angle, so its result is discarded.
        PRIME: begin
          if (cordic_done)
            state <= RUN;
        end
        // When a result is dropped because the FIFO is full, z0 is held so
        // the core recomputes the same angle.
        RUN: begin
          if (push) begin
            if (past_stop) begin
`ifdef CORDIC_SWEEP_CONTINUOUS_EN
              z0_out     <= 7'(ANGLE_START);
              sweep_done <= 1'b1;
`else
              state <= FLUSH;
`endif
            end else begin
              z0_out <= next_angle[6:0];
            end
          end
        end
        FLUSH: begin
          if (count == '0) begin
            sweep_done <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_sweep_ctrl.sv
// Randomized bench for cordic_sweep_ctrl. It uses a free-running 14-cycle core
// model. The expected result stream comes from the arithmetic angle sequence
// START, START+STEP, ... <= STOP, with cos = 2*angle and sin = 3*angle.
module tb_cordic_sweep_ctrl;

  localparam int START = 0;
  localparam int STOP  = 18;
  localparam int STEP  = 1;
  localparam int DEPTH = 4;
  localparam int PASS  = 14;

  logic               CLK = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic               busy;
  logic [6:0]         z0_out;
  logic               cordic_done = 1'b0;
  logic signed [15:0] cordic_cos = '0;
  logic signed [15:0] cordic_sin = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [6:0]         out_angle;
  logic signed [15:0] out_cos;
  logic signed [15:0] out_sin;
  logic               sweep_done;

  logic               start2 = 1'b0;
  logic               busy2;
  logic [6:0]         z0_2;
  logic signed [15:0] cos2_in = '0;
  logic signed [15:0] sin2_in = '0;
  logic               out_valid2;
  logic [6:0]         out_angle2;
  logic signed [15:0] out_cos2;
  logic signed [15:0] out_sin2;
  logic               sweep_done2;

  always #5 CLK = ~CLK;

  cordic_sweep_ctrl #(.ANGLE_START(START), .ANGLE_STOP(STOP), .ANGLE_STEP(STEP),
                      .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .reset(reset), .start(start), .busy(busy), .z0_out(z0_out),
    .cordic_done(cordic_done), .cordic_cos(cordic_cos), .cordic_sin(cordic_sin),
    .out_valid(out_valid), .out_ready(out_ready), .out_angle(out_angle),
    .out_cos(out_cos), .out_sin(out_sin), .sweep_done(sweep_done));

  cordic_sweep_ctrl #(.ANGLE_START(3), .ANGLE_STOP(10), .ANGLE_STEP(4),
                      .FIFO_DEPTH(4)) dut2 (
    .CLK(CLK), .reset(reset), .start(start2), .busy(busy2), .z0_out(z0_2),
    .cordic_done(cordic_done), .cordic_cos(cos2_in), .cordic_sin(sin2_in),
    .out_valid(out_valid2), .out_ready(1'b1), .out_angle(out_angle2),
    .out_cos(out_cos2), .out_sin(out_sin2), .sweep_done(sweep_done2));

  int n_vec = 0;
  int n_err = 0;

  int exp_arr[$];
  int exp_idx = 0;
  bit m_busy = 0;
  bit saw_done = 0;
  int n_deliv = 0;
  int rdy_mode = 0;   // 0 low, 1 high, 2 random, 3 high exactly on the next done
  bit start_req = 0;
  bit start2_req = 0;
  bit reset_req = 0;
  int cnt = 0;
  logic [6:0] lat = '0;
  logic [6:0] lat2 = '0;
  int got2[$];
  int n_done2 = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs();
    if (sweep_done) begin
      saw_done = 1;
      chk("done_while_busy", int'(m_busy), 1);
      chk("done_all_delivered", exp_idx, exp_arr.size());
      chk("done_fifo_empty", int'(out_valid), 0);
      m_busy = 0;
    end
    chk("busy", int'(busy), int'(m_busy));
    if (out_valid) begin
      if (exp_idx >= exp_arr.size()) begin
        chk("extra_entry", int'(out_angle), -1);
      end else begin
        chk("head_angle", int'(out_angle), exp_arr[exp_idx]);
        chk("head_cos", int'(out_cos), 2 * exp_arr[exp_idx]);
        chk("head_sin", int'(out_sin), 3 * exp_arr[exp_idx]);
      end
    end
    if (out_valid2) begin
      got2.push_back(int'(out_angle2));
      chk("dut2_cos", int'(out_cos2), 2 * int'(out_angle2));
      chk("dut2_sin", int'(out_sin2), 3 * int'(out_angle2));
    end
    if (sweep_done2) n_done2++;
  endtask

  // Advance one cycle: check at the falling edge, then drive the next inputs.
  task automatic tick();
    @(negedge CLK);
    check_outputs();
    cnt = (cnt == PASS - 1) ? 0 : cnt + 1;
    if (cnt == 0) begin
      lat  = z0_out;
      lat2 = z0_2;
    end
    cordic_done = (cnt == PASS - 1);
    cordic_cos  = 16'(2 * int'(lat));
    cordic_sin  = 16'(3 * int'(lat));
    cos2_in     = 16'(2 * int'(lat2));
    sin2_in     = 16'(3 * int'(lat2));
    case (rdy_mode)
      0: out_ready = 1'b0;
      1: out_ready = 1'b1;
      3: begin
        out_ready = cordic_done;
        if (cordic_done) rdy_mode = 2;
      end
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    reset = reset_req;
    reset_req = 0;
    start2 = start2_req;
    start2_req = 0;
    start = 1'b0;
    if (start_req) begin
      start = 1'b1;
      start_req = 0;
      if (!m_busy && !reset) begin
        m_busy  = 1;
        exp_idx = 0;
      end
    end
    if (reset) begin
      m_busy  = 0;
      exp_idx = 0;
    end else if (out_valid && out_ready) begin
      exp_idx++;
      n_deliv++;
    end
  endtask

  task automatic wait_done(input int budget, input string name);
    saw_done = 0;
    for (int i = 0; i < budget && !saw_done; i++) tick();
    chk({name, "_timeout"}, int'(saw_done), 1);
  endtask

  task automatic do_reset();
    reset_req = 1;
    tick();
    tick();
  endtask

  initial begin
    for (int a = START; a <= STOP; a += STEP) exp_arr.push_back(a);
    if (exp_arr.size() == 0) exp_arr.push_back(START);

    // Reset values
    do_reset();
    chk("rst_busy", int'(busy), 0);
    chk("rst_z0", int'(z0_out), START);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_angle", int'(out_angle), 0);
    chk("rst_cos", int'(out_cos), 0);
    chk("rst_sin", int'(out_sin), 0);
    chk("rst_sweep_done", int'(sweep_done), 0);

    // Default sweep with ready high; dut2 runs its short 3/10/4 sweep alongside
    rdy_mode = 1;
    n_deliv = 0;
    start_req = 1;
    start2_req = 1;
    repeat (30) tick();
    start_req = 1;   // arrives while busy and must be ignored
    wait_done(800, "sweep1");
    chk("sweep1_count", n_deliv, 19);
    chk("dut2_count", got2.size(), 2);
    if (got2.size() == 2) begin
      chk("dut2_first", got2[0], 3);
      chk("dut2_second", got2[1], 7);
    end
    chk("dut2_done_pulses", n_done2, 1);
    chk("dut2_idle", int'(busy2), 0);

    // Back-to-back random sweeps without reset; a stale first result would show up here
    for (int s = 0; s < 3; s++) begin
      rdy_mode = 2;
      repeat ($urandom_range(0, 40)) tick();
      n_deliv = 0;
      start_req = 1;
      repeat ($urandom_range(5, 60)) tick();
      start_req = 1;
      wait_done(2000, "rand_sweep");
      chk("rand_sweep_count", n_deliv, 19);
    end

    // Backpressure: FIFO fills with 0..3 and z0 holds at 4
    do_reset();
    rdy_mode = 0;
    n_deliv = 0;
    start_req = 1;
    repeat (140) tick();
    chk("bp_z0_held", int'(z0_out), 4);
    chk("bp_valid", int'(out_valid), 1);
    chk("bp_head", int'(out_angle), 0);
    // Pop coincides with a done on the full FIFO, so the push is rejected
    rdy_mode = 3;
    for (int i = 0; i < 40 && rdy_mode == 3; i++) tick();
    chk("bp_sync_timeout", rdy_mode, 2);
    rdy_mode = 0;
    tick();
    chk("bp_retry_z0", int'(z0_out), 4);
    chk("bp_after_pop_head", int'(out_angle), 1);
    rdy_mode = 2;
    wait_done(2000, "bp_sweep");
    chk("bp_count", n_deliv, 19);

    // Reset while RUN is at angle 9
    do_reset();
    rdy_mode = 1;
    start_req = 1;
    for (int i = 0; i < 400 && z0_out != 7'd9; i++) tick();
    chk("reach_angle9", int'(z0_out), 9);
    reset_req = 1;
    tick();
    tick();
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_z0", int'(z0_out), 0);
    n_deliv = 0;
    start_req = 1;
    wait_done(800, "post_reset_sweep");
    chk("post_reset_count", n_deliv, 19);
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
